// File: rtl/radix4_booth_mult_seq_pkg.sv
// Shared types and the Booth digit decoder for the iterative radix-4 multiplier.
package radix4_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
    booth_digit_t d;
    case (triplet)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/radix4_booth_mult_seq_if.sv
// Operand request and result handshake bundle for radix4_booth_mult_seq.
interface radix4_booth_mult_seq_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] C;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_signed, A, B, in_tag, out_ready,
    input  in_ready, out_valid, C, out_tag
  );

  modport slave (
    input  in_valid, in_signed, A, B, in_tag, out_ready,
    output in_ready, out_valid, C, out_tag
  );
endinterface

// File: rtl/radix4_booth_mult_seq_pp.sv
// Radix-4 Booth partial-product selector: digit x extended multiplicand.
module radix4_booth_pp
  import radix4_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] mcand,
  input  booth_digit_t     digit,
  output logic [WIDTH+2:0] pp
);

  logic [WIDTH+2:0] m1;
  logic [WIDTH+2:0] m2;

  // Select +/-1x or +/-2x of the sign-extended multiplicand.
  always_comb begin
    m1 = {mcand[WIDTH+1], mcand};
    m2 = {mcand, 1'b0};
    case (digit)
      POS1:    pp = m1;
      POS2:    pp = m2;
      NEG1:    pp = ~m1 + {{(WIDTH+2){1'b0}}, 1'b1};
      NEG2:    pp = ~m2 + {{(WIDTH+2){1'b0}}, 1'b1};
      default: pp = {(WIDTH+3){1'b0}};
    endcase
  end

endmodule

// File: rtl/radix4_booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional macro RADIX4_MULT_ZERO_BYPASS_EN: a zero operand finishes one cycle after acceptance.
module radix4_booth_mult_seq
  import radix4_mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                   CLK,
  input  logic                   rst,
  radix4_booth_mult_seq_if.slave bus,
  output logic                   busy
);

  localparam int ITER  = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(ITER);
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_t             state;
  logic [WIDTH+1:0]   mcand;
  logic [WIDTH+2:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [TAG_W-1:0]   tag;
  logic [ACC_W-1:0]   acc;

  booth_digit_t       digit;
  logic [WIDTH+2:0]   pp;
  logic [ACC_W-1:0]   pp_ext;
  logic [CNT_W:0]     shamt;
  logic [ACC_W-1:0]   acc_next;
  logic               last_step;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH+1:0]   ext_a;
  logic [WIDTH+1:0]   ext_b;

`ifdef RADIX4_MULT_ZERO_BYPASS_EN
  logic               zero_op;
`endif

  radix4_booth_pp #(.WIDTH(WIDTH)) u_pp (
    .mcand (mcand),
    .digit (digit),
    .pp    (pp)
  );

  // Operand extension for capture: sign- or zero-extend to WIDTH+2 bits.
  always_comb begin
    if (bus.in_signed) begin
      ext_a = {{2{bus.A[WIDTH-1]}}, bus.A};
      ext_b = {{2{bus.B[WIDTH-1]}}, bus.B};
    end else begin
      ext_a = {2'b00, bus.A};
      ext_b = {2'b00, bus.B};
    end
  end

  // Digit i lives in the low triplet of the shifting multiplier; its weight is 4^i.
  always_comb begin
    digit    = booth_decode(mplier[2:0]);
    shamt    = {LAST - cnt, 1'b0};
    pp_ext   = {{(WIDTH+1){pp[WIDTH+2]}}, pp};
    acc_next = acc + (pp_ext << shamt);
    result   = acc_next[2*WIDTH-1:0];
    last_step = (cnt == {CNT_W{1'b0}});
`ifdef RADIX4_MULT_ZERO_BYPASS_EN
    if (zero_op) begin
      last_step = 1'b1;
      result    = {(2*WIDTH){1'b0}};
    end else begin
      last_step = (cnt == {CNT_W{1'b0}});
      result    = acc_next[2*WIDTH-1:0];
    end
`endif
  end

  // Control FSM with registered handshake outputs and the datapath registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.C         <= {(2*WIDTH){1'b0}};
      bus.out_tag   <= {TAG_W{1'b0}};
      busy          <= 1'b0;
      acc           <= {ACC_W{1'b0}};
      mcand         <= {(WIDTH+2){1'b0}};
      mplier        <= {(WIDTH+3){1'b0}};
      cnt           <= {CNT_W{1'b0}};
      tag           <= {TAG_W{1'b0}};
`ifdef RADIX4_MULT_ZERO_BYPASS_EN
      zero_op       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            mcand        <= ext_a;
            mplier       <= {ext_b, 1'b0};
            tag          <= bus.in_tag;
            acc          <= {ACC_W{1'b0}};
            cnt          <= LAST;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= CALC;
`ifdef RADIX4_MULT_ZERO_BYPASS_EN
            zero_op      <= (bus.A == {WIDTH{1'b0}}) || (bus.B == {WIDTH{1'b0}});
`endif
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier >> 2;
          if (last_step) begin
            bus.C         <= result;
            bus.out_tag   <= tag;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // in_ready comes back only after the handshake edge, so no same-cycle re-accept.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            bus.out_valid <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_booth_mult_seq.sv
// Table-driven and scoreboard bench for radix4_booth_mult_seq (WIDTH=32, TAG_W=4).
module tb_radix4_booth_mult_seq;

  localparam int W    = 32;
  localparam int T    = 4;
  localparam int ITER = W / 2 + 1;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [T-1:0] tag;
    logic [2*W-1:0] c;
    int           hold;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] c;
    logic [T-1:0]   tag;
  } exp_t;

  logic CLK;
  logic rst;
  logic busy;
  int   checks;
  int   failures;
  exp_t sb[$];
  vec_t vecs[10];

  radix4_booth_mult_seq_if #(.WIDTH(W), .TAG_W(T)) bus ();

  radix4_booth_mult_seq #(.WIDTH(W), .TAG_W(T)) dut (
    .CLK  (CLK),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Wait for in_ready, present the operands for one accepting edge, push expectation.
  task automatic accept(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [T-1:0] tag, input logic [2*W-1:0] c);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    check("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    bus.in_signed = sgn;
    bus.A         = a;
    bus.B         = b;
    bus.in_tag    = tag;
    bus.in_valid  = 1'b1;
    e.c   = c;
    e.tag = tag;
    sb.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    bus.in_valid  = 1'b0;
    bus.A         = $urandom;
    bus.B         = $urandom;
    bus.in_signed = ~sgn;
    bus.in_tag    = ~tag;
  endtask

  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [T-1:0] tag, input logic [2*W-1:0] c, input int hold);
    int   lat;
    int   lat_exp;
    logic rdy_err;
    logic busy_err;
    exp_t e;
    lat_exp = ITER;
`ifdef RADIX4_MULT_ZERO_BYPASS_EN
    if (a == {W{1'b0}} || b == {W{1'b0}}) lat_exp = 1;
`endif
    accept(sgn, a, b, tag, c);
    rdy_err  = 1'b0;
    busy_err = 1'b0;
    lat      = 0;
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (bus.in_ready !== 1'b0) rdy_err = 1'b1;
      if (busy !== 1'b1) busy_err = 1'b1;
      bus.in_valid = (bus.out_valid !== 1'b1) && (lat % 2 == 1);
    end while (bus.out_valid !== 1'b1 && lat < 100);
    check("latency", 64'(lat), 64'(lat_exp));
    check("in_ready_low_busy", {63'd0, rdy_err}, 64'd0);
    check("busy_high", {63'd0, busy_err}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_C", bus.C, sb[0].c);
      check("bp_tag", {60'd0, bus.out_tag}, {60'd0, sb[0].tag});
      bus.in_valid = (h % 2 == 0);
      bus.A        = $urandom;
      @(posedge CLK);
      @(negedge CLK);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("no_reaccept", {63'd0, bus.in_ready}, 64'd0);
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("result_C", bus.C, e.c);
      check("result_tag", {60'd0, bus.out_tag}, {60'd0, e.tag});
      check("result_valid", {63'd0, bus.out_valid}, 64'd1);
    end
    @(posedge CLK);
    @(negedge CLK);
    bus.out_ready = 1'b0;
    check("post_hs_valid", {63'd0, bus.out_valid}, 64'd0);
    check("post_hs_ready", {63'd0, bus.in_ready}, 64'd1);
    check("post_hs_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic         rs;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks   = 0;
    failures = 0;

    vecs[0] = '{1'b0, 32'd100,        32'd100,        4'd3,  64'd10000,              0};
    vecs[1] = '{1'b1, 32'hFFFFFFFF,   32'd1,          4'd5,  64'hFFFFFFFFFFFFFFFF,   0};
    vecs[2] = '{1'b0, 32'hFFFFFFFF,   32'd1,          4'd6,  64'h00000000FFFFFFFF,   0};
    vecs[3] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   4'd7,  64'hFFFFFFFE00000001,   0};
    vecs[4] = '{1'b1, 32'h80000000,   32'h80000000,   4'd8,  64'h4000000000000000,   0};
    vecs[5] = '{1'b0, 32'd0,          32'd12345,      4'd9,  64'd0,                  0};
    vecs[6] = '{1'b1, 32'hFFFFFFFD,   32'd5,          4'd10, 64'hFFFFFFFFFFFFFFF1,   0};
    vecs[7] = '{1'b1, 32'h7FFFFFFF,   32'h80000000,   4'd11, 64'hC000000080000000,   0};
    vecs[8] = '{1'b0, 32'd12345678,   32'd0,          4'd12, 64'd0,                  0};
    vecs[9] = '{1'b0, 32'd1000,       32'd3000,       4'd13, 64'd3000000,           10};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.A         = 32'd0;
    bus.B         = 32'd0;
    bus.in_tag    = 4'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_C", bus.C, 64'd0);
    check("rst_tag", {60'd0, bus.out_tag}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].c, vecs[i].hold);
    end

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = (i == 3) ? 32'd0 : W'($urandom);
      rb = W'($urandom);
      run_op(rs, ra, rb, T'(i), model(rs, ra, rb), i % 3);
    end

    // Abort mid-calculation: no result may appear, then a fresh op must work.
    accept(1'b0, 32'd123456, 32'd654321, 4'd14, model(1'b0, 32'd123456, 32'd654321));
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    rst = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("abort_C", bus.C, 64'd0);
    check("abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    sb.delete();
    rst = 1'b0;
    run_op(1'b0, 32'd7, 32'd6, 4'd2, 64'd42, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/radix4_booth_mult_seq.md
Name: radix4_booth_mult_seq

Overview:
Parametrised, iterative radix-4 Booth multiplier. Successor to the fixed 32-bit radix-4 multiplier, generalised in the following ways:
- operand width is a parameter;
- signed or unsigned mode is selected per operation;
- handshakes are full valid/ready on both sides, so the output supports backpressure;
- a user tag passes through with each operation.
It sits between issue logic and writeback in the datapath and has one operation in flight at a time.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4.
TAG_W, 4, width of the pass-through tag; must be >= 1.
ITER (localparam), WIDTH/2+1, number of Booth digits processed, one per cycle.

Ports:
CLK  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand request.
in_ready  output  1  block can accept an operand; high only in IDLE.
in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
A  input  WIDTH  multiplicand.
B  input  WIDTH  multiplier.
in_tag  input  TAG_W  tag captured at acceptance.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
C  output  2*WIDTH  product.
out_tag  output  TAG_W  tag of the operation in C.
busy  output  1  high in CALC or DONE.

Behaviour:
- Reset is synchronous and active-high on CLK.
  - While rst=1 at an edge: state becomes IDLE; C, out_tag and the accumulator go to 0; out_valid=0; busy=0; in_ready=0 during reset.
  - in_ready=1 from the first edge with rst=0.
  - Reset mid-operation aborts the operation with no output; any partial result is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: capture A, B, in_signed and in_tag; clear the accumulator; load the digit counter with ITER-1; go to CALC.
- Operand extension at capture:
  - Both operands are extended to WIDTH+2 bits: sign-extended if in_signed=1, zero-extended otherwise.
  - The multiplier gets an implicit 0 appended below its LSB.
- CALC:
  - Each edge consumes one Booth triplet {b[2i+1], b[2i], b[2i-1]} and maps it to a digit in {-2,-1,0,+1,+2}.
  - Partial product = digit × extended multiplicand, sign-extended to 2*WIDTH+4 bits, shifted left by 2i, then added to the accumulator.
  - Exactly ITER edges are spent in CALC. The counter decrements each edge; at counter==0 the state goes to DONE and C is loaded with accumulator[2*WIDTH-1:0].
  - Latency: out_valid rises ITER edges after the acceptance edge (17 for WIDTH=32), independent of the operand values.
- DONE:
  - out_valid=1; C and out_tag are held stable.
  - On out_valid&&out_ready: go to IDLE. in_ready rises on the following cycle, so there is no same-cycle re-accept.
  - out_ready low holds the result indefinitely.
- Handshake rules:
  - in_valid in CALC or DONE is ignored and the operands are not sampled.
  - Input changes after acceptance have no effect.
  - out_valid never drops without a handshake or a reset.
- Arithmetic: the result is exact modulo 2^(2*WIDTH) for both modes.
  - Boundary cases covered by this rule: signed min×min, unsigned max×max, zero operands.
  - No overflow flag.

Optional Feature:
Macro: RADIX4_MULT_ZERO_BYPASS_EN.
- Defined: if the captured A==0 or B==0 at acceptance, the FSM goes directly to DONE at the next edge with C=0 and out_tag captured, giving a latency of 1. The tag and handshake rules are unchanged.
- Undefined: zero operands take the full ITER cycles like any other operands, and no zero-detect logic is synthesised.

Decomposition:
- Package radix4_mult_pkg contains:
  - typedef enum state_t {IDLE, CALC, DONE};
  - typedef enum booth_digit_t {ZERO, POS1, POS2, NEG1, NEG2};
  - function booth_decode(triplet) returning booth_digit_t.
- One sub-module, radix4_booth_pp: combinational selector taking the multiplicand and a booth_digit_t and producing a WIDTH+3-bit signed partial product. The sequential block instantiates it once.

Test Plan (WIDTH=32, TAG_W=4):
- Unsigned, A=100, B=100, tag=3 -> C=10000 and out_tag=3 exactly 17 cycles after acceptance; in_ready=0 throughout.
- Signed, A=32'hFFFFFFFF, B=1 -> C=64'hFFFFFFFFFFFFFFFF. The same operands unsigned -> C=64'h00000000FFFFFFFF.
- Unsigned max×max, A=B=32'hFFFFFFFF -> C=64'hFFFFFFFE00000001. Signed min×min, A=B=32'h80000000 -> C=64'h4000000000000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> C, out_tag and out_valid stay stable; in_valid pulses during this time are ignored. Raising out_ready gives a one-cycle handshake, then in_ready=1.
- Reset mid-operation: assert rst at cycle 8 of CALC -> next cycle out_valid=0, C=0, in_ready=0. After rst drops, a new op 7×6 -> C=42.
- Zero operand, A=0, B=12345 -> C=0. Latency is 1 cycle with RADIX4_MULT_ZERO_BYPASS_EN defined and 17 cycles without it.
